// File: rtl/aes_sbox_byte_sequencer.sv
// Front-end sequencer for the three-stage S-box datapath: serialises one 128-bit state
// into 16 byte issues, reassembles the in-order substituted returns and guards the return path.
module aes_sbox_byte_sequencer #(
    parameter int SBOX_LATENCY = 3
) (
    input  logic         in_clock,
    input  logic         in_reset_n,
    input  logic [127:0] in_state,
    input  logic         in_valid,
    output logic         out_ready,
    output logic [7:0]   out_byte,
    output logic         out_byte_valid,
    input  logic [7:0]   in_sub,
    input  logic         in_sub_valid,
    output logic [127:0] out_state,
    output logic         out_valid,
    input  logic         in_ready,
    output logic         out_err
);

    localparam logic [4:0] NUM_BYTES  = 5'd16;
    // Last cycle in which the final return may still arrive; the verdict is taken at its end.
    localparam logic [4:0] LAST_CYCLE = 5'(16 + SBOX_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e       state_q;
    logic [127:0] blk_q;
    logic [127:0] res_q;
    logic [4:0]   issue_q;
    logic [4:0]   ret_q;
    logic [4:0]   cyc_q;
    logic         out_ready_q;
    logic [7:0]   out_byte_q;
    logic         out_byte_valid_q;
    logic [127:0] out_state_q;
    logic         out_valid_q;
    logic         out_err_q;

    logic [127:0] res_d;
    logic [4:0]   ret_d;
    logic         capture_s;
    logic         all_ret_s;
    logic         accept_s;
    logic         deadline_s;
    logic         more_issue_s;
    logic [7:0]   next_byte_s;

    // Return capture, handshake qualifiers and the next byte to issue.
    always_comb begin
        res_d        = res_q;
        ret_d        = ret_q;
        capture_s    = (state_q == ISSUE) && in_sub_valid && (ret_q < NUM_BYTES);
        if (capture_s) begin
            res_d[{ret_q[3:0], 3'b000} +: 8] = in_sub;
            ret_d                            = ret_q + 5'd1;
        end else begin
            res_d = res_q;
            ret_d = ret_q;
        end
        all_ret_s    = (ret_d == NUM_BYTES);
        accept_s     = (state_q == IDLE) && in_valid && out_ready_q;
        deadline_s   = (cyc_q == LAST_CYCLE);
        more_issue_s = (issue_q < NUM_BYTES);
        next_byte_s  = blk_q[{issue_q[3:0], 3'b000} +: 8];
    end

    // Sequencer FSM; every output comes straight from a register.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q          <= IDLE;
            blk_q            <= 128'd0;
            res_q            <= 128'd0;
            issue_q          <= 5'd0;
            ret_q            <= 5'd0;
            cyc_q            <= 5'd0;
            out_ready_q      <= 1'b0;
            out_byte_q       <= 8'h00;
            out_byte_valid_q <= 1'b0;
            out_state_q      <= 128'd0;
            out_valid_q      <= 1'b0;
            out_err_q        <= 1'b0;
        end else begin
            out_err_q        <= 1'b0;
            out_byte_q       <= 8'h00;
            out_byte_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    out_ready_q <= 1'b1;
                    if (accept_s) begin
                        // Byte 0 leaves on the accepting edge so the 16 issues are gap-free.
                        blk_q            <= in_state;
                        res_q            <= 128'd0;
                        ret_q            <= 5'd0;
                        issue_q          <= 5'd1;
                        cyc_q            <= 5'd1;
                        out_byte_q       <= in_state[7:0];
                        out_byte_valid_q <= 1'b1;
                        out_ready_q      <= 1'b0;
                        state_q          <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_q <= res_d;
                    ret_q <= ret_d;
                    cyc_q <= cyc_q + 5'd1;
                    if (all_ret_s) begin
                        out_state_q <= res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (deadline_s) begin
                        // Partial result is dropped; out_ready stays low for the error cycle.
                        res_q     <= 128'd0;
                        out_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end else if (more_issue_s) begin
                        out_byte_q       <= next_byte_s;
                        out_byte_valid_q <= 1'b1;
                        issue_q          <= issue_q + 5'd1;
                    end
                end
                DONE: begin
                    if (in_ready) begin
                        out_valid_q <= 1'b0;
                        out_state_q <= 128'd0;
                        out_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    out_state_q <= 128'd0;
                    out_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_ready      = out_ready_q;
    assign out_byte       = out_byte_q;
    assign out_byte_valid = out_byte_valid_q;
    assign out_state      = out_state_q;
    assign out_valid      = out_valid_q;
    assign out_err        = out_err_q;

endmodule
